// File: rtl/div_pkg.sv
// Shared types and width-generic helpers for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int MAXW = 64;
  typedef logic [MAXW-1:0] wide_t;

  function automatic int cw_of(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

  // Helpers work on a MAXW container; only the low w bits are meaningful.
  function automatic wide_t neg_w(input wide_t v, input int unsigned w);
    wide_t mask;
    mask = (w >= MAXW) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
    return (~v + wide_t'(1)) & mask;
  endfunction

  function automatic wide_t abs_w(input wide_t v, input int unsigned w);
    return (((v >> (w - 1)) & wide_t'(1)) != '0) ? neg_w(v, w) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a VW-bit partial remainder.
module div_step #(
  parameter int VW = 16
) (
  input  logic [VW-1:0] rem,
  input  logic          qmsb,
  input  logic [VW-1:0] dmag,
  output logic [VW-1:0] rem_next,
  output logic          qbit
);

  logic [VW:0] diff;

  always_comb begin
    diff = {rem, qmsb} - {1'b0, dmag};
    if (!diff[VW]) begin
      rem_next = diff[VW-1:0];
      qbit     = 1'b1;
    end else begin
      rem_next = {rem[VW-2:0], qmsb};
      qbit     = 1'b0;
    end
  end

endmodule

// File: rtl/restoring_divider_param.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional signed mode,
// divide-by-zero and overflow flags, results held in DONE.
module restoring_divider_param
  import div_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int VW = 16,
  localparam int CW = cw_of(DW)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic          is_signed,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          busy,
  output logic          ready,
  output logic          div_by_zero,
  output logic          ovf,
  output logic [CW-1:0] counter
);

  div_state_t    state, state_n;
  logic          accept;
  logic          b_zero;
  logic          a_neg, b_neg, a_min, zdiv;
  logic [DW-1:0] amag;
  logic [VW-1:0] bmag;
  logic [VW-1:0] rem, rem_n;
  logic          qbit;

  assign b_zero = (b == '0);

  div_step #(.VW(VW)) u_step (
    .rem      (rem),
    .qmsb     (amag[DW-1]),
    .dmag     (bmag),
    .rem_next (rem_n),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  // b==0 skips RUN and reports through FIX, giving the one-edge latency.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = b_zero ? FIX : RUN;
        end
      end
      RUN:     if (counter == CW'(DW - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      a_min       <= 1'b0;
      zdiv        <= 1'b0;
      amag        <= '0;
      bmag        <= '0;
      rem         <= '0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
      counter     <= '0;
    end else if (accept) begin
      a_neg       <= is_signed & a[DW-1];
      b_neg       <= is_signed & b[VW-1];
      a_min       <= is_signed & a[DW-1] & (a[DW-2:0] == '0);
      zdiv        <= b_zero;
      amag        <= is_signed ? DW'(abs_w(wide_t'(a), DW)) : a;
      bmag        <= is_signed ? VW'(abs_w(wide_t'(b), VW)) : b;
      // The remainder register carries a[VW-1:0] through to r on divide-by-zero.
      rem         <= b_zero ? a[VW-1:0] : '0;
      busy        <= 1'b1;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
      counter     <= '0;
    end else if (state == RUN) begin
      rem     <= rem_n;
      amag    <= {amag[DW-2:0], qbit};
      counter <= counter + CW'(1);
    end else if (state == FIX) begin
      busy  <= 1'b0;
      ready <= 1'b1;
      if (zdiv) begin
        q           <= '1;
        r           <= rem;
        div_by_zero <= 1'b1;
      end else begin
        q   <= (a_neg ^ b_neg) ? DW'(neg_w(wide_t'(amag), DW)) : amag;
        r   <= a_neg ? VW'(neg_w(wide_t'(rem), VW)) : rem;
        ovf <= a_min & amag[DW-1];
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider_param.sv
// Self-checking bench for restoring_divider_param at 32/16 and 8/4 widths.
module tb_restoring_divider_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, start, sel, is_signed;
  logic [63:0] a_in, b_in;
  logic        start32, start8;

  logic [31:0] q32;  logic [15:0] r32;  logic [5:0] cnt32;
  logic        busy32, ready32, dz32, ov32;
  logic [7:0]  q8;   logic [3:0]  r8;   logic [3:0] cnt8;
  logic        busy8, ready8, dz8, ov8;

  logic [63:0] sq, sr, scnt;
  logic        sbusy, sready, sdz, sov;

  int n_chk = 0;
  int n_fail = 0;

  assign start32 = start & ~sel;
  assign start8  = start & sel;

  restoring_divider_param #(.DW(32), .VW(16)) dut32 (
    .clk(clk), .clear(clear), .start(start32), .is_signed(is_signed),
    .a(a_in[31:0]), .b(b_in[15:0]), .q(q32), .r(r32), .busy(busy32),
    .ready(ready32), .div_by_zero(dz32), .ovf(ov32), .counter(cnt32)
  );

  restoring_divider_param #(.DW(8), .VW(4)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .is_signed(is_signed),
    .a(a_in[7:0]), .b(b_in[3:0]), .q(q8), .r(r8), .busy(busy8),
    .ready(ready8), .div_by_zero(dz8), .ovf(ov8), .counter(cnt8)
  );

  always_comb begin
    sq = '0; sr = '0; scnt = '0;
    sbusy = 1'b0; sready = 1'b0; sdz = 1'b0; sov = 1'b0;
    if (sel) begin
      sq = 64'(q8); sr = 64'(r8); scnt = 64'(cnt8);
      sbusy = busy8; sready = ready8; sdz = dz8; sov = ov8;
    end else begin
      sq = 64'(q32); sr = 64'(r32); scnt = 64'(cnt32);
      sbusy = busy32; sready = ready32; sdz = dz32; sov = ov32;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: truncating division on plain integers.
  function automatic void model(input int dw, input int vw, input logic [63:0] av_i,
                                input logic [63:0] bv_i, input bit sg,
                                output logic [63:0] eq, output logic [63:0] er,
                                output bit edz, output bit eov);
    longint sa, sb, qq, rr, qa;
    logic [63:0] dm, vm, av, bv;
    dm = (64'd1 << dw) - 64'd1;
    vm = (64'd1 << vw) - 64'd1;
    av = av_i & dm;
    bv = bv_i & vm;
    edz = 1'b0;
    eov = 1'b0;
    if (bv == 64'd0) begin
      eq = dm; er = av & vm; edz = 1'b1;
    end else if (sg) begin
      sa = longint'(av); if (av[dw-1]) sa = sa - longint'(64'd1 << dw);
      sb = longint'(bv); if (bv[vw-1]) sb = sb - longint'(64'd1 << vw);
      qq = sa / sb;
      rr = sa % sb;
      qa = (qq < 0) ? -qq : qq;
      eov = (av == (64'd1 << (dw - 1))) && (qa >= longint'(64'd1 << (dw - 1)));
      eq = 64'(qq) & dm;
      er = 64'(rr) & vm;
    end else begin
      eq = av / bv; er = av % bv;
    end
  endfunction

  task automatic run_op(input bit s8, input logic [63:0] av, input logic [63:0] bv,
                        input bit sg, input int pulse_at,
                        input logic [63:0] eq, input logic [63:0] er,
                        input bit edz, input bit eov);
    int dw, n;
    bit got;
    dw = s8 ? 8 : 32;
    @(negedge clk);
    sel = s8; a_in = av; b_in = bv; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = ~av; b_in = ~bv | 64'd1; is_signed = ~sg;
    chk("busy_at_accept", 64'(sbusy), 64'd1);
    chk("ready_at_accept", 64'(sready), 64'd0);
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      if (n == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      got = sready;
    end
    chk("latency", 64'(n), edz ? 64'd1 : 64'(dw + 1));
    chk("q", sq, eq);
    chk("r", sr, er);
    chk("div_by_zero", 64'(sdz), 64'(edz));
    chk("ovf", 64'(sov), 64'(eov));
    chk("counter", scnt, edz ? 64'd0 : 64'(dw));
    chk("busy_done", 64'(sbusy), 64'd0);
  endtask

  task automatic check_zero32(input string tag);
    chk({tag, "_q"}, 64'(q32), 64'd0);
    chk({tag, "_r"}, 64'(r32), 64'd0);
    chk({tag, "_busy"}, 64'(busy32), 64'd0);
    chk({tag, "_ready"}, 64'(ready32), 64'd0);
    chk({tag, "_dz"}, 64'(dz32), 64'd0);
    chk({tag, "_ovf"}, 64'(ov32), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt32), 64'd0);
  endtask

  typedef struct {
    bit          s8;
    logic [63:0] a, b;
    bit          sg;
    logic [63:0] q, r;
    bit          dz, ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    logic [63:0] av, bv, eq, er;
    bit sg, edz, eov;

    tbl[0] = '{1'b0, 64'd1000,       64'd7,      1'b0, 64'd142,        64'd6,      1'b0, 1'b0};
    tbl[1] = '{1'b0, 64'hFFFFFC18,   64'd7,      1'b1, 64'hFFFFFF72,   64'hFFFA,   1'b0, 1'b0};
    tbl[2] = '{1'b0, 64'd1000,       64'hFFF9,   1'b1, 64'hFFFFFF72,   64'd6,      1'b0, 1'b0};
    tbl[3] = '{1'b0, 64'h12345678,   64'd0,      1'b0, 64'hFFFFFFFF,   64'h5678,   1'b1, 1'b0};
    tbl[4] = '{1'b0, 64'h80000000,   64'hFFFF,   1'b1, 64'h80000000,   64'd0,      1'b0, 1'b1};
    tbl[5] = '{1'b0, 64'hFFFFFFFF,   64'hFFFF,   1'b0, 64'h00010001,   64'd0,      1'b0, 1'b0};
    tbl[6] = '{1'b1, 64'd200,        64'd9,      1'b0, 64'd22,         64'd2,      1'b0, 1'b0};
    tbl[7] = '{1'b1, 64'h80,         64'hF,      1'b1, 64'h80,         64'd0,      1'b0, 1'b1};

    clear = 1'b1; start = 1'b0; sel = 1'b0; is_signed = 1'b0; a_in = '0; b_in = '0;
    #12;
    check_zero32("reset");
    chk("reset_q8", 64'(q8), 64'd0);
    chk("reset_ready8", 64'(ready8), 64'd0);
    chk("reset_cnt8", 64'(cnt8), 64'd0);
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].s8, tbl[i].a, tbl[i].b, tbl[i].sg, -1,
             tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);

    // start pulsed mid-run with scrambled operands must be ignored
    run_op(1'b0, 64'd1000, 64'd7, 1'b0, 9, 64'd142, 64'd6, 1'b0, 1'b0);

    // start held high in DONE: back-to-back operations
    @(negedge clk);
    sel = 1'b0; a_in = 64'd1000; b_in = 64'd7; is_signed = 1'b0; start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("b2b_ready_drop", 64'(sready), 64'd0);
      n = 0;
      while (!sready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_latency", 64'(n), 64'd33);
      chk("b2b_q", sq, 64'd142);
      chk("b2b_r", sr, 64'd6);
    end
    start = 1'b0;

    // asynchronous clear mid-RUN
    @(negedge clk);
    sel = 1'b0; a_in = 64'd1000; b_in = 64'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (scnt != 64'd17 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cnt_reached_17", scnt, 64'd17);
    #2 clear = 1'b1;
    #1;
    check_zero32("midrun_clear");
    @(negedge clk);
    clear = 1'b0;
    run_op(1'b0, 64'd1000, 64'd7, 1'b0, -1, 64'd142, 64'd6, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      av = {32'h0, $urandom};
      bv = {48'h0, 16'($urandom)};
      case ($urandom_range(0, 7))
        0: bv = 64'd0;
        1: bv = 64'($urandom_range(1, 3));
        2: bv = 64'hFFFF;
        default: ;
      endcase
      model(32, 16, av, bv, sg, eq, er, edz, eov);
      run_op(1'b0, av, bv, sg, -1, eq, er, edz, eov);
    end

    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom_range(0, 1));
      av = 64'($urandom_range(0, 255));
      bv = 64'($urandom_range(0, 15));
      model(8, 4, av, bv, sg, eq, er, edz, eov);
      run_op(1'b1, av, bv, sg, -1, eq, er, edz, eov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
